// File: rtl/bias_buf_bank_wrapper.sv
// Banked bias/parameter buffer shared between a host burst port and an EPU single-port path.
// Optional byte strobes are enabled with `define BIAS_BUF_WSTRB_EN.
`timescale 1ns/1ps

module bias_buf_bank_wrapper #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 512,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = $clog2(DEPTH*NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_sel_i,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    input  logic [ADDR_W-1:0] ar_addr_i,
    input  logic [7:0]        ar_len_i,
    input  logic              aw_valid_i,
    output logic              aw_ready_o,
    input  logic [ADDR_W-1:0] aw_addr_i,
    input  logic [7:0]        aw_len_i,
    input  logic              w_valid_i,
    output logic              w_ready_o,
    input  logic [DATA_W-1:0] w_data_i,
`ifdef BIAS_BUF_WSTRB_EN
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic [DATA_W/8-1:0] epu_wstrb_i,
`endif
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_last_o,
    output logic              wr_done_o,
    input  logic              start_i,
    input  logic              finish_i,
    output logic              busy_o,
    input  logic              epu_cs_i,
    input  logic              epu_oe_i,
    input  logic              epu_we_i,
    input  logic [ADDR_W-1:0] epu_addr_i,
    input  logic [DATA_W-1:0] epu_wdata_i,
    output logic [DATA_W-1:0] epu_rdata_o
);

    localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int TOTAL  = DEPTH * NUM_BANKS;

    typedef enum logic [2:0] {IDLE, EPU_RW, RD, WR, WR_RESP} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        len_q;
    logic [8:0]        beat_cnt;
    logic              rd_issue;
    logic              wr_beat;
    logic              in_flight;
    logic              in_flight_last;
    logic [2:0]        rd_occ;

    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              fifo_rp;
    logic              fifo_wp;
    logic [1:0]        fifo_cnt;
    logic              push;
    logic              pop;

    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [31:0]       acc_addr_ext;
    logic [BANK_W-1:0] acc_bank;
    logic [ROW_W-1:0]  acc_row;
`ifdef BIAS_BUF_WSTRB_EN
    logic [DATA_W/8-1:0] acc_strb;
`endif

    logic [DATA_W-1:0] bank_q_arr [NUM_BANKS];
    logic [DATA_W-1:0] bank_q;
    logic [BANK_W-1:0] rd_bank_q;
    logic              epu_rd_pend;
    logic [DATA_W-1:0] epu_hold;

    assign r_valid_o = (fifo_cnt != 2'd0);
    assign pop       = r_valid_o && r_ready_i;
    assign push      = in_flight;
    assign r_data_o  = r_valid_o ? fifo_data[fifo_rp] : '0;
    assign r_last_o  = r_valid_o && fifo_last[fifo_rp];
    assign busy_o    = (state != IDLE);
    assign bank_q    = bank_q_arr[rd_bank_q];
    assign next_addr = (cur_addr == ADDR_W'(TOTAL - 1)) ? '0 : cur_addr + ADDR_W'(1);

    // A read is only launched if its data is guaranteed a FIFO slot on return.
    assign rd_occ   = 3'(fifo_cnt) + 3'(in_flight) - 3'(pop);
    assign rd_issue = (state == RD) && (beat_cnt <= {1'b0, len_q}) && (rd_occ < 3'd2);
    assign wr_beat  = (state == WR) && w_valid_i;

    always_comb begin
        state_nx   = state;
        ar_ready_o = 1'b0;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        wr_done_o  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = EPU_RW;
                end else if (ar_valid_i && host_sel_i) begin
                    state_nx   = RD;
                    ar_ready_o = 1'b1;
                end else if (aw_valid_i && host_sel_i) begin
                    state_nx   = WR;
                    aw_ready_o = 1'b1;
                end
            end
            EPU_RW: begin
                if (finish_i && start_i) state_nx = IDLE;
            end
            RD: begin
                if (pop && fifo_last[fifo_rp]) state_nx = IDLE;
            end
            WR: begin
                w_ready_o = 1'b1;
                if (w_valid_i && (beat_cnt == {1'b0, len_q})) state_nx = WR_RESP;
            end
            WR_RESP: begin
                wr_done_o = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single bank access per cycle, sourced from whichever side owns the buffer.
    always_comb begin
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = cur_addr;
        acc_wdata = w_data_i;
`ifdef BIAS_BUF_WSTRB_EN
        acc_strb  = w_strb_i;
`endif
        case (state)
            EPU_RW: begin
                acc_en    = epu_cs_i && (epu_we_i || epu_oe_i);
                acc_we    = epu_cs_i && epu_we_i;
                acc_addr  = epu_addr_i;
                acc_wdata = epu_wdata_i;
`ifdef BIAS_BUF_WSTRB_EN
                acc_strb  = epu_wstrb_i;
`endif
            end
            RD: acc_en = rd_issue;
            WR: begin
                acc_en = wr_beat;
                acc_we = wr_beat;
            end
            default: acc_en = 1'b0;
        endcase
        acc_addr_ext = 32'(acc_addr);
        acc_bank     = BANK_W'(acc_addr_ext % NUM_BANKS);
        acc_row      = ROW_W'(acc_addr_ext / NUM_BANKS);
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] q;
        logic              bank_en;

        assign bank_en       = acc_en && (acc_bank == BANK_W'(b));
        assign bank_q_arr[b] = q;

        always_ff @(posedge clk) begin
            if (bank_en) begin
                if (acc_we) begin
`ifdef BIAS_BUF_WSTRB_EN
                    for (int i = 0; i < DATA_W/8; i++) begin
                        if (acc_strb[i]) mem[acc_row][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                    end
`else
                    mem[acc_row] <= acc_wdata;
`endif
                end else begin
                    q <= mem[acc_row];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cur_addr       <= '0;
            len_q          <= '0;
            beat_cnt       <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            fifo_last      <= '0;
            fifo_rp        <= 1'b0;
            fifo_wp        <= 1'b0;
            fifo_cnt       <= '0;
            rd_bank_q      <= '0;
            epu_rd_pend    <= 1'b0;
            epu_hold       <= '0;
        end else begin
            state <= state_nx;
            if (ar_ready_o) begin
                cur_addr <= ar_addr_i;
                len_q    <= ar_len_i;
                beat_cnt <= '0;
            end else if (aw_ready_o) begin
                cur_addr <= aw_addr_i;
                len_q    <= aw_len_i;
                beat_cnt <= '0;
            end else if (rd_issue || wr_beat) begin
                cur_addr <= next_addr;
                beat_cnt <= beat_cnt + 9'd1;
            end
            in_flight      <= rd_issue;
            in_flight_last <= rd_issue && (beat_cnt == {1'b0, len_q});
            if (acc_en) rd_bank_q <= acc_bank;
            if (push) begin
                fifo_last[fifo_wp] <= in_flight_last;
                fifo_wp            <= ~fifo_wp;
            end
            if (pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
            epu_rd_pend <= (state == EPU_RW) && acc_en && !acc_we;
            if (epu_rd_pend) epu_hold <= bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_data[fifo_wp] <= bank_q;
    end

    // The read register is visible the cycle after the access and held afterwards.
    assign epu_rdata_o = epu_rd_pend ? bank_q : epu_hold;

endmodule

// File: doc/bias_buf_bank_wrapper.md
Name: bias_buf_bank_wrapper

Overview:
- Parametrised, banked bias/parameter buffer with two access paths: a host burst port (AXI-side slave path) and an EPU single-port path.
- Successor to the single-bank 2k bias wrapper. Adds configurable width, depth and bank count, multi-beat bursts, read backpressure through a 2-entry output queue, and a write-completion pulse.
- Only one side owns the SRAM at a time. EPU ownership is bracketed by start_i/finish_i.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 512, words per bank.
- NUM_BANKS, 4, bank count; power of two, at least 1.
- ADDR_W, $clog2(DEPTH*NUM_BANKS), word-address width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- host_sel_i  in  1  host slave selected; same role as the enable in the previous generation.
- ar_valid_i  in  1  read request valid.
- ar_ready_o  out  1  read request accepted.
- ar_addr_i  in  ADDR_W  start word address of the read burst.
- ar_len_i  in  8  read burst beats minus 1.
- aw_valid_i  in  1  write request valid.
- aw_ready_o  out  1  write request accepted.
- aw_addr_i  in  ADDR_W  start word address of the write burst.
- aw_len_i  in  8  write burst beats minus 1.
- w_valid_i  in  1  write beat valid.
- w_ready_o  out  1  write beat accepted.
- w_data_i  in  DATA_W  write data.
- r_valid_o  out  1  read beat valid.
- r_ready_i  in  1  read beat accepted by the host.
- r_data_o  out  DATA_W  read data.
- r_last_o  out  1  final read beat of the burst.
- wr_done_o  out  1  one-cycle pulse after the last write beat.
- start_i  in  1  EPU requests buffer ownership.
- finish_i  in  1  EPU releases the buffer.
- busy_o  out  1  state is not IDLE.
- epu_cs_i, epu_oe_i, epu_we_i  in  1 each  EPU chip select, output enable, write enable.
- epu_addr_i  in  ADDR_W  EPU word address.
- epu_wdata_i  in  DATA_W  EPU write data.
- epu_rdata_o  out  DATA_W  EPU read data; 1-cycle registered latency.

Behaviour:
- Banking: bank = addr mod NUM_BANKS; row = addr / NUM_BANKS. Each bank is a synchronous single-port SRAM with 1-cycle read latency. One bank access per cycle.
- States: IDLE, EPU_RW, RD, WR, WR_RESP.
- IDLE transitions, in priority order:
  - start_i goes to EPU_RW.
  - else ar_valid_i & host_sel_i goes to RD.
  - else aw_valid_i & host_sel_i goes to WR.
- ar_ready_o / aw_ready_o pulse for one cycle, only on the IDLE transition into RD / WR. On that cycle, addr and len are latched and the beat counter is cleared.
- EPU_RW:
  - Bank port is driven directly from the epu_* inputs; a write occurs when cs & we.
  - epu_rdata_o holds the last read (when cs & oe, not we).
  - Exit to IDLE when finish_i & start_i. Host requests are not accepted, and their ready outputs stay 0.
- RD:
  - Issue a read when beats remain and (queue count + in-flight − (r_valid_o & r_ready_i)) < 2. This gives one beat per cycle when r_ready_i is held high.
  - Returned data enters a 2-entry FIFO; r_valid_o = FIFO not empty.
  - r_data_o and r_last_o must stay stable while r_valid_o & !r_ready_i.
  - r_last_o is asserted with beat len.
  - Return to IDLE on the cycle the last beat is accepted.
- WR:
  - w_ready_o = 1; each w_valid_i writes w_data_i at the current address.
  - After beat len is written, go to WR_RESP. Extra beats are never accepted.
- WR_RESP: wr_done_o = 1 for one cycle, then IDLE.
- Address increments by 1 per beat and wraps from DEPTH*NUM_BANKS−1 to 0.
- host_sel_i dropping mid-burst has no effect; bursts always complete.
- Reset, including mid-burst: state IDLE, FIFO and counters cleared. All outputs 0: ready, valid, last, done, busy, and both data outputs. SRAM contents are undefined.
- SRAM outputs are gated: the bank enable is low in IDLE. No bank is written outside EPU_RW/WR.

Optional Feature:
- Macro BIAS_BUF_WSTRB_EN.
- Defined: adds port w_strb_i (in, DATA_W/8) and port epu_wstrb_i (in, DATA_W/8). Only bytes whose strobe bit is 1 are written; other bytes keep their old value. DATA_W must be a multiple of 8.
- Undefined: those ports do not exist, and every write updates the full word.

Test Plan:
- Reset mid read burst (len=7, after 3 beats) -> next cycle all outputs 0, busy_o=0. A new ar burst then returns correct data starting at beat 0.
- Write burst addr=0, len=3, data 0x11..0x44, then read addr=0, len=3 with r_ready_i=1 -> four r_valid_o cycles back to back with data 0x11,0x22,0x33,0x44. r_last_o only on 0x44. wr_done_o pulses once.
- Read len=5 with r_ready_i toggling 1,0,0,1,... -> no lost or duplicated beats. r_data_o stable during stalls. No more than 2 entries queued.
- Wrap: write addr=2047 (default params), len=1 -> words 2047 and 0 written. Read back both.
- start_i and ar_valid_i asserted in the same IDLE cycle -> EPU_RW entered, ar_ready_o stays 0. After finish_i & start_i the read is accepted.
- EPU writes 0xDEADBEEF at addr 5, then reads addr 5 -> epu_rdata_o=0xDEADBEEF one cycle after the read. With BIAS_BUF_WSTRB_EN and strobe 0b0001 over 0x000000AA, the result is 0xDEADBEAA.
